// File: rtl/wb_line_mem_responder.sv
// Wishbone-style line memory slave: 128-bit line reads/writes, fixed latency.
// Ports: cyc/stb/we/adr/sel/dat_i in; dat_o/ack/retry/busy out. Opt: WB_LINE_MEM_RETRY_INJECT_EN.
`timescale 1ns/1ps
module wb_line_mem_responder #(
  parameter int LINE_W       = 128,
  parameter int DEPTH        = 64,
  parameter int LATENCY      = 4,
  parameter int RETRY_PERIOD = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cyc,
  input  logic                stb,
  input  logic                we,
  input  logic [15:0]         adr,
  input  logic [LINE_W/8-1:0] sel,
  input  logic [LINE_W-1:0]   dat_i,
  output logic [LINE_W-1:0]   dat_o,
  output logic                ack,
  output logic                retry,
  output logic                busy
);

  localparam int SEL_W = LINE_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_RETRY
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [LINE_W-1:0]  wdat_q, wdat_d;
  logic [LINE_W-1:0]  dat_o_q, dat_o_d;

  logic [LINE_W-1:0]  mem [DEPTH];

  logic               cur_we;
  logic [IDX_W-1:0]   cur_idx;
  logic [SEL_W-1:0]   cur_sel;
  logic [LINE_W-1:0]  cur_dat;
  logic [LINE_W-1:0]  lane_mask;
  logic               fin;
  logic               rty_due;
  logic               commit;
  logic               unused_adr;

  assign unused_adr = ^{adr[3:0], adr[15:4+IDX_W]};

  // Live inputs on the accept edge (LATENCY==1), latched copies after.
  always_comb begin
    cur_we  = we_q;
    cur_idx = idx_q;
    cur_sel = sel_q;
    cur_dat = wdat_q;
    if (state_q == S_IDLE) begin
      cur_we  = we;
      cur_idx = adr[4 +: IDX_W];
      cur_sel = sel;
      cur_dat = dat_i;
    end
  end

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < SEL_W; i++) begin
      lane_mask[8*i +: 8] = {8{cur_sel[i]}};
    end
  end

`ifdef WB_LINE_MEM_RETRY_INJECT_EN
  localparam logic [7:0] RP_LAST = 8'(RETRY_PERIOD - 1);
  logic [7:0] rcnt_q, rcnt_d;

  // Advanced only on completion, so aborted requests never count.
  always_comb begin
    rcnt_d  = rcnt_q;
    rty_due = (rcnt_q == RP_LAST);
    if (fin) begin
      rcnt_d = rty_due ? 8'd0 : rcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
    end
  end

  assign retry = (state_q == S_RETRY);
`else
  assign rty_due = 1'b0;
  assign retry   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    dat_o_d = '0;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cyc && stb) begin
          we_d   = we;
          idx_d  = adr[4 +: IDX_W];
          sel_d  = sel;
          wdat_d = dat_i;
          cnt_d  = LAT_M1;
          if (LATENCY == 1) begin
            fin = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!(cyc && stb)) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          fin = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK, S_RETRY: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (fin) begin
      if (rty_due) begin
        state_d = S_RETRY;
      end else begin
        state_d = S_ACK;
        if (!cur_we) begin
          dat_o_d = mem[cur_idx] & lane_mask;
        end
      end
    end
  end

  // rst_n gate keeps a held request from writing while in reset.
  assign commit = rst_n && fin && !rty_due && cur_we;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (cur_sel[i]) begin
          mem[cur_idx][8*i +: 8] <= cur_dat[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      dat_o_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      dat_o_q <= dat_o_d;
    end
  end

  assign ack   = (state_q == S_ACK);
  assign busy  = (state_q != S_IDLE);
  assign dat_o = dat_o_q;

endmodule

// File: tb/tb_wb_line_mem_responder.sv
// Scoreboard bench for wb_line_mem_responder.
// Driver pushes expected responses; negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_wb_line_mem_responder;

  localparam int LW  = 128;
  localparam int DEP = 64;
  localparam int LAT = 4;
  localparam int RP  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cyc, stb, we;
  logic [15:0]   adr;
  logic [15:0]   sel;
  logic [LW-1:0] dat_i;
  logic [LW-1:0] dat_o;
  logic          ack, retry, busy;

  wb_line_mem_responder #(
    .LINE_W(LW), .DEPTH(DEP), .LATENCY(LAT), .RETRY_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we),
    .adr(adr), .sel(sel), .dat_i(dat_i), .dat_o(dat_o),
    .ack(ack), .retry(retry), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            rty;
    logic [LW-1:0] data;
  } exp_t;

  exp_t          sbq[$];
  logic [LW-1:0] model [DEP];
  int            tests = 0;
  int            fails = 0;
  int            rcnt_m = 0;
  bit            at_ack = 0;

  function automatic logic [LW-1:0] lmask(logic [15:0] s);
    logic [LW-1:0] m;
    for (int i = 0; i < 16; i++) m[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic int line_of(logic [15:0] a);
    return (int'(a) >> 4) % DEP;
  endfunction

  function automatic bit predict_retry();
`ifdef WB_LINE_MEM_RETRY_INJECT_EN
    if (rcnt_m == RP - 1) begin
      rcnt_m = 0;
      return 1'b1;
    end
    rcnt_m++;
`endif
    return 1'b0;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(string name, logic [LW-1:0] got, logic [LW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("ack_retry_excl", LW'(ack && retry), '0);
      if (ack || retry) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp ack=%b retry=%b", ack, retry);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("resp_kind", LW'(retry), LW'(e.rty));
          check("resp_data", dat_o, e.data);
        end
      end else begin
        check("dat_o_idle", dat_o, '0);
      end
    end
  end

  task automatic idle(int n);
    cyc = 0;
    stb = 0;
    at_ack = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_req(bit w, logic [15:0] a, logic [15:0] s,
                           logic [LW-1:0] d, int exp_acc);
    int n;
    cyc = 1; stb = 1; we = w; adr = a; sel = s; dat_i = d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!busy && n < 20);
    check("accept_delay", LW'(n), LW'(exp_acc));
    we = 1'($urandom);
    adr = 16'($urandom);
    sel = 16'($urandom);
    dat_i = rnd_line();
  endtask

  task automatic do_req(bit w, logic [15:0] a, logic [15:0] s,
                        logic [LW-1:0] d, int exp_acc,
                        output bit acked, output logic [LW-1:0] got);
    exp_t e;
    int   idx;
    int   n;
    idx = line_of(a);
    e.rty = predict_retry();
    e.data = (e.rty || w) ? '0 : (model[idx] & lmask(s));
    if (!e.rty && w) model[idx] = (model[idx] & ~lmask(s)) | (d & lmask(s));
    sbq.push_back(e);
    start_req(w, a, s, d, exp_acc);
    n = 0;
    while (!(ack || retry) && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ack_latency", LW'(n), LW'(LAT - 1));
    acked = ack;
    got = dat_o;
    at_ack = 1;
  endtask

  task automatic xfer(bit w, logic [15:0] a, logic [15:0] s,
                      logic [LW-1:0] d, output logic [LW-1:0] got);
    bit ok;
    for (int t = 0; t < 4; t++) begin
      do_req(w, a, s, d, 1, ok, got);
      idle(1);
      if (ok) break;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] got, got2, d;
    logic [LW-1:0] pat;
    bit ok, ok2;
    int exp_acc;
    cyc = 0; stb = 0; we = 0; adr = 0; sel = 0; dat_i = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", LW'(ack), '0);
    check("rst_retry", LW'(retry), '0);
    check("rst_busy", LW'(busy), '0);
    check("rst_dat_o", dat_o, '0);
    rst_n = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < DEP; i++) xfer(1, 16'(i << 4), 16'hFFFF, rnd_line(), got);

    pat = 128'h0123456789ABCDEF0123456789ABCDEF;
    xfer(1, 16'h0040, 16'hFFFF, pat, got);
    xfer(0, 16'h0040, 16'hFFFF, '0, got);
    check("roundtrip", got, pat);

    xfer(1, 16'h0030, 16'hFFFF, {LW{1'b1}}, got);
    xfer(1, 16'h0030, 16'h00FF, '0, got);
    xfer(0, 16'h0030, 16'hFFFF, '0, got);
    check("byte_mask", got, {{64{1'b1}}, 64'h0});

    start_req(1, 16'h0050, 16'hFFFF, rnd_line(), 1);
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_ack", LW'(ack), '0);
    cyc = 0;
    stb = 0;
    @(posedge clk);
    #1;
    check("abort_busy", LW'(busy), '0);
    check("abort_ack", LW'(ack), '0);
    idle(1);
    xfer(0, 16'h0050, 16'hFFFF, '0, got);

    d = rnd_line();
    do_req(1, 16'h0410, 16'hFFFF, d, 1, ok, got);
    do_req(0, 16'h0010, 16'hFFFF, '0, 2, ok2, got2);
    idle(1);
    if (ok && ok2) check("alias_b2b", got2, d);

    xfer(1, 16'h0020, 16'h0000, rnd_line(), got);
    xfer(0, 16'h0020, 16'h0000, '0, got);
    check("sel0_read", got, '0);
    xfer(0, 16'h0020, 16'hFFFF, '0, got);

    for (int k = 0; k < 80; k++) begin
      logic [15:0] s;
      s = 16'($urandom);
      if ($urandom_range(0, 7) == 0) s = 16'h0000;
      if ($urandom_range(0, 7) == 0) s = 16'hFFFF;
      if (at_ack && $urandom_range(0, 2) == 0) begin
        exp_acc = 2;
      end else begin
        if (at_ack) idle(1);
        exp_acc = 1;
      end
      do_req(1'($urandom), 16'($urandom), s, rnd_line(), exp_acc, ok, got);
    end
    idle(1);

    start_req(1, 16'h0070, 16'hFFFF, rnd_line(), 1);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check("mid_rst_ack", LW'(ack), '0);
    check("mid_rst_retry", LW'(retry), '0);
    check("mid_rst_busy", LW'(busy), '0);
    check("mid_rst_dat_o", dat_o, '0);
    cyc = 0;
    stb = 0;
    rcnt_m = 0;
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
    xfer(0, 16'h0070, 16'hFFFF, '0, got);

    idle(2);
    check("queue_empty", LW'(sbq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
